tt_pin_bus_responder: RTL and testbench

Byte-wide register-access responder that sits behind the Tiny Tapeout pin interface inside `tt_um_camdenmil_sky25b`. An external host drives command and data bytes on `ui_in` with a 4-phase req/ack handshake on the bidirectional pins. The block executes register reads and writes and returns response bytes on `uo_out`. The design core observes its configuration through the register outputs.

---
 rtl/tt_pin_bus_pkg.sv | 28 ++
 rtl/tt_pin_bus_responder_sync2.sv | 27 ++
 rtl/tt_pin_bus_responder.sv | 167 ++++++++++++++++
 tb/tb_tt_pin_bus_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pin_bus_pkg.sv
// Shared definitions for the Tiny Tapeout pin-bus register responder.
//   state_t        : handshake FSM states
//   RESP_ERR       : response byte returned for a malformed command
//   STATUS_ADDR    : register index used as the status register
//   CMD_RD_BIT     : command byte bit selecting read (1) / write (0)
//   CMD_PAD_MSB    : highest command bit that must be zero above the address
//   cmd_is_legal() : checks that bits [CMD_PAD_MSB:addr_w] are all zero
package tt_pin_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD_ACK,
    ST_WAIT_DATA,
    ST_DATA_ACK
  } state_t;

  localparam logic [7:0]  RESP_ERR    = 8'hEE;
  localparam int unsigned STATUS_ADDR = 1;
  localparam int unsigned CMD_RD_BIT  = 7;
  localparam int unsigned CMD_PAD_MSB = 6;

  function automatic logic cmd_is_legal(input logic [7:0] cmd, input int unsigned addr_w);
    logic [6:0] pad;
    pad = cmd[CMD_PAD_MSB:0] >> addr_w;
    return (pad == '0);
  endfunction

endpackage

// File: rtl/tt_pin_bus_responder_sync2.sv
// Two-flop synchronizer for asynchronous inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both stages clear to 0
//   d     : asynchronous input
//   q     : synchronized output (two clk edges of latency)
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/tt_pin_bus_responder.sv
// Byte-wide register-access responder behind the Tiny Tapeout pins.
// The host sends a command byte (and, for writes, a data byte) on ui_in,
// each framed by a 4-phase req/ack handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : design selected; low forces the FSM to IDLE
//   ui_in      : host command/data byte
//   uio_in     : bit 0 = req from host (asynchronous)
//   uo_out     : response byte (valid while ack is high)
//   uio_out    : bit 1 = ack, others 0
//   uio_oe     : constant 8'b0000_0010 (only ack is driven)
//   regs_o     : flattened register contents, reg0 = ID_VALUE
module tt_pin_bus_responder
  import tt_pin_bus_pkg::*;
#(
  parameter int unsigned NREGS    = 8,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [7:0]         ui_in,
  input  logic [7:0]         uio_in,
  output logic [7:0]         uo_out,
  output logic [7:0]         uio_out,
  output logic [7:0]         uio_oe,
  output logic [NREGS*8-1:0] regs_o
);

  localparam int unsigned ADDR_W    = $clog2(NREGS);
  // Register 1 doubles as the status register only in the full 8-register map.
  localparam logic        STATUS_EN = (NREGS == 8);
  localparam logic [ADDR_W-1:0] STATUS_IDX = ADDR_W'(STATUS_ADDR);

  logic              req_s;
  logic              unused_uio;

  state_t            state_q, state_d;
  logic [7:0]        uo_q, uo_d;
  logic              ack_q;
  logic              err_q, err_d;
  logic              wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_ok;
  logic              reg_we;
  logic [7:0]        regs_q   [NREGS];
  logic [7:0]        reg_view [NREGS];

  assign unused_uio = ^uio_in[7:1];

  sync2 #(.WIDTH(1)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uio_in[0]),
    .q     (req_s)
  );

  // Architectural view of the register map: reg0 is the fixed ID and,
  // when enabled, reg1 reflects the sticky error flag.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      reg_view[i] = regs_q[i];
    end
    reg_view[0] = ID_VALUE;
    if (STATUS_EN) begin
      reg_view[STATUS_ADDR] = {err_q, 7'b0};
    end
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_o[i*8 +: 8] = reg_view[i];
    end
  end

  assign cmd_addr = ui_in[ADDR_W-1:0];
  assign cmd_ok   = cmd_is_legal(ui_in, ADDR_W);

  always_comb begin
    state_d   = state_q;
    uo_d      = uo_q;
    err_d     = err_q;
    wr_pend_d = wr_pend_q;
    addr_d    = addr_q;
    reg_we    = 1'b0;

    if (!ena) begin
      state_d   = ST_IDLE;
      wr_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_s) begin
            state_d   = ST_CMD_ACK;
            wr_pend_d = 1'b0;
            if (!cmd_ok) begin
              uo_d  = RESP_ERR;
              err_d = 1'b1;
            end else if (ui_in[CMD_RD_BIT]) begin
              uo_d = reg_view[cmd_addr];
            end else begin
              addr_d    = cmd_addr;
              wr_pend_d = 1'b1;
            end
          end
        end
        ST_CMD_ACK: begin
          if (!req_s) begin
            state_d = wr_pend_q ? ST_WAIT_DATA : ST_IDLE;
          end
        end
        ST_WAIT_DATA: begin
          if (req_s) begin
            state_d   = ST_DATA_ACK;
            uo_d      = ui_in;
            wr_pend_d = 1'b0;
            if (STATUS_EN && (addr_q == STATUS_IDX)) begin
              if (ui_in[7]) begin
                err_d = 1'b0;
              end
            end else if (addr_q != '0) begin
              reg_we = 1'b1;
            end
          end
        end
        ST_DATA_ACK: begin
          if (!req_s) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      uo_q      <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      wr_pend_q <= 1'b0;
      addr_q    <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      uo_q      <= uo_d;
      // ack is registered from the next state so it rises on the same edge
      // the FSM enters an acknowledge state.
      ack_q     <= (state_d == ST_CMD_ACK) || (state_d == ST_DATA_ACK);
      err_q     <= err_d;
      wr_pend_q <= wr_pend_d;
      addr_q    <= addr_d;
      if (reg_we) begin
        regs_q[addr_q] <= ui_in;
      end
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {6'b0, ack_q, 1'b0};
  assign uio_oe  = 8'b0000_0010;

endmodule

// File: tb/tb_tt_pin_bus_responder.sv
module tb_tt_pin_bus_responder;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [7:0]  ui_in;
  logic [7:0]  uio_in;
  logic [7:0]  uo_out;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic [63:0] regs_o;

  int checks = 0;
  int errors = 0;

  // Reference model: register map as the host sees it.
  logic [7:0] m_reg [8];
  logic       m_err;
  logic [7:0] m_uo;
  logic       m_wr_pend;
  logic [2:0] m_waddr;

  tt_pin_bus_responder #(.NREGS(8), .ID_VALUE(8'hA5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .regs_o  (regs_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input int unsigned a);
    if (a == 0) return 8'hA5;
    if (a == 1) return {m_err, 7'b0};
    return m_reg[a];
  endfunction

  function automatic logic [63:0] m_regs_flat();
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = m_read(i);
    return w;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_err = 1'b0;
    m_uo = 8'h00;
    m_wr_pend = 1'b0;
    m_waddr = 3'd0;
  endtask

  // Byte arriving from IDLE: interpret as a command.
  task automatic m_cmd(input logic [7:0] b);
    m_wr_pend = 1'b0;
    if (b[6:3] != 4'd0) begin
      m_err = 1'b1;
      m_uo = 8'hEE;
    end else if (b[7]) begin
      m_uo = m_read(b[2:0]);
    end else begin
      m_wr_pend = 1'b1;
      m_waddr = b[2:0];
    end
  endtask

  task automatic m_data(input logic [7:0] d);
    m_uo = d;
    m_wr_pend = 1'b0;
    if (m_waddr == 3'd1) begin
      if (d[7]) m_err = 1'b0;
    end else if (m_waddr != 3'd0) begin
      m_reg[m_waddr] = d;
    end
  endtask

  // Raise req with byte b, count edges until ack, check latency/response.
  task automatic req_up(input string tag, input logic [7:0] b);
    int n;
    @(negedge clk);
    ui_in = b;
    uio_in[0] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (uio_out[1] !== 1'b1 && n < 12);
    chk({tag, "_rise_lat"}, n, 3);
    chk({tag, "_uo"}, uo_out, m_uo);
    chk({tag, "_regs"}, regs_o, m_regs_flat());
  endtask

  task automatic req_down(input string tag);
    int n;
    @(negedge clk);
    uio_in[0] = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (uio_out[1] !== 1'b0 && n < 12);
    chk({tag, "_fall_lat"}, n, 3);
  endtask

  task automatic send_cmd(input string tag, input logic [7:0] b);
    m_cmd(b);
    req_up(tag, b);
    req_down(tag);
  endtask

  task automatic send_data(input string tag, input logic [7:0] d);
    m_data(d);
    req_up(tag, d);
    req_down(tag);
  endtask

  initial begin
    logic [7:0] rb;
    rst_n = 1'b0;
    ena = 1'b1;
    ui_in = 8'h00;
    uio_in = 8'h00;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'h02);
    chk("rst_regs", regs_o, 64'h0000_0000_0000_00A5);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write then read back
    send_cmd("wr3_cmd", 8'h03);
    send_data("wr3_data", 8'h5C);
    chk("reg3", regs_o[31:24], 8'h5C);
    send_cmd("rd3", 8'h83);
    chk("rd3_val", uo_out, 8'h5C);

    // ID protection
    send_cmd("wr0_cmd", 8'h00);
    send_data("wr0_data", 8'hFF);
    send_cmd("rd0", 8'h80);
    chk("rd0_val", uo_out, 8'hA5);

    // Illegal command, status read, status clear
    send_cmd("illegal", 8'h48);
    chk("illegal_val", uo_out, 8'hEE);
    send_cmd("rd_status_set", 8'h81);
    chk("status_set_val", uo_out, 8'h80);
    send_cmd("wr1_cmd", 8'h01);
    send_data("wr1_data", 8'h80);
    send_cmd("rd_status_clr", 8'h81);
    chk("status_clr_val", uo_out, 8'h00);

    // ena drop while waiting for write data
    send_cmd("wr5_cmd", 8'h05);
    @(negedge clk);
    ena = 1'b0;
    m_wr_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ena_low_ack", uio_out, 8'h00);
    chk("ena_low_uo", uo_out, m_uo);
    @(negedge clk);
    ena = 1'b1;
    send_cmd("after_ena", 8'h77);
    chk("after_ena_val", uo_out, 8'hEE);
    chk("reg5_kept", regs_o[47:40], 8'h00);
    chk("err_after_ena", regs_o[15:8], 8'h80);

    // Randomized transactions against the model
    for (int t = 0; t < 40; t++) begin
      rb = 8'($urandom);
      if ((t % 3) == 0) rb[6:3] = 4'd0;
      send_cmd("rnd_cmd", rb);
      if (m_wr_pend) send_data("rnd_data", 8'($urandom));
    end

    // Reset during DATA_ACK with req held through release
    send_cmd("wr6_cmd", 8'h06);
    m_data(8'h3C);
    req_up("wr6_data", 8'h3C);
    chk("reg6", regs_o[55:48], 8'h3C);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("midrst_ack", uio_out, 8'h00);
    chk("midrst_uo", uo_out, 8'h00);
    chk("midrst_regs", regs_o, m_regs_flat());
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // req still high: 0x3C is now taken as a (malformed) command
    m_cmd(8'h3C);
    begin
      int n;
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (uio_out[1] !== 1'b1 && n < 12);
      chk("post_rst_rise_lat", n, 3);
      chk("post_rst_uo", uo_out, 8'hEE);
      chk("post_rst_regs", regs_o, m_regs_flat());
    end
    req_down("post_rst");
    send_cmd("post_rst_rd6", 8'h86);
    chk("post_rst_reg6", uo_out, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
